// File: rtl/servo_pkg.sv
// ---------------------------------------------------------------------------
// servo_pkg
// Shared definitions for the servo pulse decoder and the servo PWM generator.
//   - servo_state_e    : decoder FSM state encoding
//   - DIV_W            : datapath width of the sequential divider
//   - DUTY_FULL_SCALE  : decoded level that corresponds to MAX_PULSE_NS
//   - LOST_PERIODS     : frames without a rising edge before signal loss
//   - ns_to_count()    : converts a duration in ns to clock cycles
//   - period_count()   : clock cycles in one servo frame
// ---------------------------------------------------------------------------
package servo_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOW  = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2,
    ST_CONVERT   = 2'd3
  } servo_state_e;

  localparam int unsigned DIV_W           = 32;
  localparam int unsigned DUTY_FULL_SCALE = 1000;
  localparam int unsigned LOST_PERIODS    = 2;

  // Product is formed in 64 bits: 50 MHz * 2e6 ns does not fit in 32.
  function automatic int unsigned ns_to_count(input int unsigned freq_hz,
                                              input int unsigned ns);
    logic [63:0] prod;
    prod = (64'(freq_hz) * 64'(ns)) / 64'd1_000_000_000;
    return prod[31:0];
  endfunction

  function automatic int unsigned period_count(input int unsigned freq_hz,
                                               input int unsigned refresh_hz);
    return freq_hz / refresh_hz;
  endfunction

endpackage

// File: rtl/servo_div_seq.sv
// ---------------------------------------------------------------------------
// servo_div_seq
// Restoring unsigned divider, one quotient bit per clock, DIV_W bits.
// The first iteration is executed on the clock that accepts 'start', so the
// result is presented with 'done' exactly DIV_W clocks after start.
// A start while a division is running is ignored.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, aborts any running division
//   start    : one-cycle request, samples dividend/divisor
//   dividend : numerator
//   divisor  : denominator (non-zero)
//   quotient : result, valid while done is high and held afterwards
//   done     : one-cycle strobe, quotient ready
// ---------------------------------------------------------------------------
module servo_div_seq
  import servo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(DIV_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIV_W-1:0] rem_in;
  logic [DIV_W-1:0] quo_in;
  logic [DIV_W:0]   shifted;
  logic [DIV_W:0]   trial;

  always_comb begin
    // A fresh division starts from remainder 0 and the new dividend.
    rem_in  = busy_q ? rem_q : '0;
    quo_in  = busy_q ? quo_q : dividend;
    shifted = {rem_in, quo_in[DIV_W-1]};
    trial   = shifted - {1'b0, divisor};

    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (busy_q || start) begin
      if (!trial[DIV_W]) begin
        rem_d = trial[DIV_W-1:0];
        quo_d = {quo_in[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[DIV_W-1:0];
        quo_d = {quo_in[DIV_W-2:0], 1'b0};
      end

      if (busy_q) begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        cnt_d  = CNT_ONE;
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// ---------------------------------------------------------------------------
// servo_pulse_decoder
// Measures the high time of an RC-servo pulse and converts it to a level in
// 0..1000 (MIN_PULSE_NS -> 0, MAX_PULSE_NS -> 1000). Pulses inside the
// tolerance band around the nominal range are clamped; pulses outside it are
// rejected with pulse_err. signal_lost rises when no rising edge has been
// seen for two frame periods and falls with the next decoded pulse.
// Optional build macro: SERVO_DECODE_FILTER_EN adds a 4-sample glitch filter
// after the synchronizer (both edges delayed by 4 clocks, width preserved).
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   pwm_in      : asynchronous servo pulse input
//   duty_level  : last decoded level, 0..1000
//   duty_valid  : one-cycle strobe, duty_level updated this cycle
//   pulse_err   : one-cycle strobe, pulse rejected (too short / too long)
//   signal_lost : high while no rising edge seen within 2 frame periods
// ---------------------------------------------------------------------------
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int unsigned INPUT_FREQ   = 50_000_000,
  parameter int unsigned REFRESH_HZ   = 50,
  parameter int unsigned MIN_PULSE_NS = 1_000_000,
  parameter int unsigned MAX_PULSE_NS = 2_000_000,
  parameter int unsigned TOL_NS       = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [9:0] duty_level,
  output logic       duty_valid,
  output logic       pulse_err,
  output logic       signal_lost
);

  localparam int unsigned MIN_COUNT    = ns_to_count(INPUT_FREQ, MIN_PULSE_NS);
  localparam int unsigned MAX_COUNT    = ns_to_count(INPUT_FREQ, MAX_PULSE_NS);
  localparam int unsigned TOL_COUNT    = ns_to_count(INPUT_FREQ, TOL_NS);
  localparam int unsigned PERIOD_COUNT = period_count(INPUT_FREQ, REFRESH_HZ);
  localparam int unsigned LOST_COUNT   = LOST_PERIODS * PERIOD_COUNT;
  localparam int unsigned LOW_LIMIT    = (MIN_COUNT > TOL_COUNT) ? MIN_COUNT - TOL_COUNT : 0;
  localparam int unsigned HIGH_LIMIT   = MAX_COUNT + TOL_COUNT;
  localparam logic [DIV_W-1:0] SPAN    = DIV_W'(MAX_COUNT - MIN_COUNT);

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic [1:0] sync_q, sync_d;
  logic       sig;
  logic       prev_q, prev_d;
  logic       sig_rise;
  logic       sig_fall;

  assign sync_d = {sync_q[0], pwm_in};

`ifdef SERVO_DECODE_FILTER_EN
  // filt_q only follows the synchronizer after four consecutive samples that
  // disagree with it; any agreeing sample restarts the run.
  logic       filt_q, filt_d;
  logic [1:0] filt_cnt_q, filt_cnt_d;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = 2'd0;
    if (sync_q[1] != filt_q) begin
      if (filt_cnt_q == 2'd3) begin
        filt_d = sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= 2'd0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign sig = filt_q;
`else
  assign sig = sync_q[1];
`endif

  assign prev_d   = sig;
  assign sig_rise = sig & ~prev_q;
  assign sig_fall = ~sig & prev_q;

  // -------------------------------------------------------------------------
  // Divider
  // -------------------------------------------------------------------------
  logic             div_start;
  logic [DIV_W-1:0] div_dividend;
  logic [DIV_W-1:0] div_quotient;
  logic             div_done;

  servo_div_seq u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (SPAN),
    .quotient (div_quotient),
    .done     (div_done)
  );

  // -------------------------------------------------------------------------
  // Measurement FSM
  // -------------------------------------------------------------------------
  servo_state_e state_q, state_d;
  logic [31:0]  high_count_q, high_count_d;
  logic [31:0]  clamped;
  logic [9:0]   duty_level_q, duty_level_d;
  logic         duty_valid_q, duty_valid_d;
  logic         pulse_err_q, pulse_err_d;

  always_comb begin
    clamped = high_count_q;
    if (high_count_q < MIN_COUNT) clamped = MIN_COUNT;
    if (high_count_q > MAX_COUNT) clamped = MAX_COUNT;
  end

  always_comb begin
    state_d      = state_q;
    high_count_d = high_count_q;
    duty_level_d = duty_level_q;
    duty_valid_d = 1'b0;
    pulse_err_d  = 1'b0;
    div_start    = 1'b0;
    div_dividend = '0;

    case (state_q)
      ST_WAIT_LOW: begin
        if (!sig) state_d = ST_WAIT_RISE;
      end

      ST_WAIT_RISE: begin
        if (sig_rise) begin
          state_d      = ST_MEASURE;
          high_count_d = 32'd1;       // the rising-edge cycle is a high cycle
        end
      end

      ST_MEASURE: begin
        // The fall is checked first: a pulse of exactly HIGH_LIMIT clocks
        // sees its falling edge in the cycle where the count equals the limit.
        if (sig_fall) begin
          if (high_count_q < LOW_LIMIT) begin
            pulse_err_d = 1'b1;
            state_d     = ST_WAIT_LOW;
          end else begin
            div_start    = 1'b1;
            div_dividend = (clamped - MIN_COUNT) * DUTY_FULL_SCALE;
            state_d      = ST_CONVERT;
          end
        end else if (high_count_q >= HIGH_LIMIT) begin
          pulse_err_d = 1'b1;
          state_d     = ST_WAIT_LOW;
        end else begin
          high_count_d = high_count_q + 32'd1;
        end
      end

      ST_CONVERT: begin
        // Input edges are deliberately ignored here; WAIT_LOW then skips a
        // pulse that is already high when the conversion finishes.
        if (div_done) begin
          duty_level_d = (div_quotient > DIV_W'(DUTY_FULL_SCALE)) ?
                         10'(DUTY_FULL_SCALE) : div_quotient[9:0];
          duty_valid_d = 1'b1;
          state_d      = ST_WAIT_LOW;
        end
      end

      default: state_d = ST_WAIT_LOW;
    endcase
  end

  // -------------------------------------------------------------------------
  // Signal-loss watchdog
  // -------------------------------------------------------------------------
  logic [31:0] since_rise_q, since_rise_d;
  logic        signal_lost_q, signal_lost_d;

  always_comb begin
    since_rise_d = since_rise_q;
    if (sig_rise) begin
      since_rise_d = '0;
    end else if (since_rise_q < LOST_COUNT) begin
      since_rise_d = since_rise_q + 32'd1;
    end

    signal_lost_d = signal_lost_q;
    // Set only on the cycle the saturating count arrives at the limit so a
    // later successful decode can clear the flag while the count is parked.
    if (since_rise_d == LOST_COUNT && since_rise_q != LOST_COUNT) signal_lost_d = 1'b1;
    if (duty_valid_d) signal_lost_d = 1'b0;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= 2'b00;
      prev_q        <= 1'b0;
      state_q       <= ST_WAIT_LOW;
      high_count_q  <= '0;
      since_rise_q  <= '0;
      duty_level_q  <= '0;
      duty_valid_q  <= 1'b0;
      pulse_err_q   <= 1'b0;
      signal_lost_q <= 1'b1;
    end else begin
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      high_count_q  <= high_count_d;
      since_rise_q  <= since_rise_d;
      duty_level_q  <= duty_level_d;
      duty_valid_q  <= duty_valid_d;
      pulse_err_q   <= pulse_err_d;
      signal_lost_q <= signal_lost_d;
    end
  end

  assign duty_level  = duty_level_q;
  assign duty_valid  = duty_valid_q;
  assign pulse_err   = pulse_err_q;
  assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// ---------------------------------------------------------------------------
// tb_servo_pulse_decoder
// Clock scaled to 500 kHz so the nominal 1..2 ms pulse maps to 500..1000
// clocks (tolerance 50) and two 250 Hz frames to 4000 clocks; every default
// test width is scaled by 1/100 accordingly.
// ---------------------------------------------------------------------------
module tb_servo_pulse_decoder;

  localparam int MINC = 500;
  localparam int MAXC = 1000;
  localparam int TOLC = 50;
`ifdef SERVO_DECODE_FILTER_EN
  localparam int FLT = 4;
`else
  localparam int FLT = 0;
`endif
  // pwm_in change -> 2 synchronizer clocks (+filter) -> fall detect -> 33 clocks
  localparam int VALID_LAT = 2 + FLT + 33;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic [9:0] duty_level;
  logic       duty_valid;
  logic       pulse_err;
  logic       signal_lost;

  int checks = 0;
  int errors = 0;
  int exp_level = 0;

  int obs_nvalid, obs_nerr, obs_valid_k, obs_err_k, obs_level;
  int obs_lost_at_valid, obs_lost_before_valid;

  servo_pulse_decoder #(
    .INPUT_FREQ   (500_000),
    .REFRESH_HZ   (250),
    .MIN_PULSE_NS (1_000_000),
    .MAX_PULSE_NS (2_000_000),
    .TOL_NS       (100_000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .duty_level  (duty_level),
    .duty_valid  (duty_valid),
    .pulse_err   (pulse_err),
    .signal_lost (signal_lost)
  );

  always #5 clk = ~clk;

  // Reference: 0 = decoded (lvl set), 1 = too short, 2 = too long.
  function automatic int model(input int w, output int lvl);
    int c;
    lvl = 0;
    if (w < MINC - TOLC) return 1;
    if (w > MAXC + TOLC) return 2;
    c = w;
    if (c < MINC) c = MINC;
    if (c > MAXC) c = MAXC;
    lvl = ((c - MINC) * 1000) / (MAXC - MINC);
    return 0;
  endfunction

  // Drives one high pulse of w clocks then low for 'low' clocks; k counts
  // rising clock edges since pwm_in went high, outputs sampled on negedges.
  task automatic drive_pulse(input int w, input int low);
    int prev_lost;
    obs_nvalid = 0; obs_nerr = 0; obs_valid_k = -1; obs_err_k = -1;
    obs_level = -1; obs_lost_at_valid = -1; obs_lost_before_valid = -1;
    @(negedge clk);
    pwm_in = 1'b1;
    prev_lost = int'(signal_lost);
    for (int k = 1; k <= w + low; k++) begin
      @(negedge clk);
      if (duty_valid) begin
        obs_nvalid++;
        obs_valid_k = k;
        obs_level = int'(duty_level);
        obs_lost_at_valid = int'(signal_lost);
        obs_lost_before_valid = prev_lost;
      end
      if (pulse_err) begin
        obs_nerr++;
        obs_err_k = k;
      end
      prev_lost = int'(signal_lost);
      if (k == w) pwm_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (duty_level !== 10'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", duty_level); end
    checks++; if (duty_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", duty_valid); end
    checks++; if (pulse_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", pulse_err); end
    checks++; if (signal_lost !== 1'b1) begin errors++; $display("FAIL reset_lost: got %b expected 1", signal_lost); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_level = 0;
    $display("reset: level=%0d valid=%b err=%b lost=%b", duty_level, duty_valid, pulse_err, signal_lost);
  endtask

  // One pulse, checked against the reference model.
  task automatic test_pulse(input int w);
    int code, lvl, exp_err_k;
    code = model(w, lvl);
    drive_pulse(w, 80);
    if (code == 0) exp_level = lvl;
    checks++; if (obs_nvalid !== ((code == 0) ? 1 : 0)) begin errors++; $display("FAIL valid_count w=%0d: got %0d expected %0d", w, obs_nvalid, (code == 0) ? 1 : 0); end
    checks++; if (obs_nerr !== ((code != 0) ? 1 : 0)) begin errors++; $display("FAIL err_count w=%0d: got %0d expected %0d", w, obs_nerr, (code != 0) ? 1 : 0); end
    if (code == 0) begin
      checks++; if (obs_valid_k - w !== VALID_LAT) begin errors++; $display("FAIL valid_latency w=%0d: got %0d expected %0d", w, obs_valid_k - w, VALID_LAT); end
      checks++; if (obs_level !== lvl) begin errors++; $display("FAIL level_at_valid w=%0d: got %0d expected %0d", w, obs_level, lvl); end
    end else begin
      exp_err_k = (code == 1) ? w + 3 + FLT : MAXC + TOLC + 3 + FLT;
      checks++; if (obs_err_k !== exp_err_k) begin errors++; $display("FAIL err_timing w=%0d: got %0d expected %0d", w, obs_err_k, exp_err_k); end
    end
    checks++; if (duty_level !== exp_level[9:0]) begin errors++; $display("FAIL level_hold w=%0d: got %0d expected %0d", w, duty_level, exp_level); end
    $display("pulse w=%0d: valid=%0d err=%0d level=%0d (model code=%0d level=%0d)", w, obs_nvalid, obs_nerr, duty_level, code, exp_level);
  endtask

  task automatic test_directed();
    int widths[12] = '{750, 500, 1000, 1025, 450, 1050, 449, 1051, 600, 250, 1500, 750};
    foreach (widths[i]) test_pulse(widths[i]);
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 4) == 0) w = int'($urandom_range(100, 1300));
      else w = int'($urandom_range(440, 1060));
      test_pulse(w);
    end
  endtask

  task automatic test_signal_lost();
    repeat (2500) @(negedge clk);
    checks++; if (signal_lost !== 1'b0) begin errors++; $display("FAIL lost_early: got %b expected 0", signal_lost); end
    repeat (1700) @(negedge clk);
    checks++; if (signal_lost !== 1'b1) begin errors++; $display("FAIL lost_timeout: got %b expected 1", signal_lost); end
    $display("idle: signal_lost=%b", signal_lost);
    drive_pulse(750, 80);
    exp_level = 500;
    checks++; if (obs_level !== 500) begin errors++; $display("FAIL lost_recover_level: got %0d expected 500", obs_level); end
    checks++; if (obs_lost_before_valid !== 1) begin errors++; $display("FAIL lost_before_valid: got %0d expected 1", obs_lost_before_valid); end
    checks++; if (obs_lost_at_valid !== 0) begin errors++; $display("FAIL lost_at_valid: got %0d expected 0", obs_lost_at_valid); end
    $display("recover pulse w=750: level=%0d lost_before=%0d lost_at_valid=%0d", obs_level, obs_lost_before_valid, obs_lost_at_valid);
  endtask

  task automatic test_glitch();
    drive_pulse(2, 80);
    checks++; if (obs_nvalid !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", obs_nvalid); end
    checks++; if (obs_nerr !== ((FLT != 0) ? 0 : 1)) begin errors++; $display("FAIL glitch_err: got %0d expected %0d", obs_nerr, (FLT != 0) ? 0 : 1); end
    checks++; if (duty_level !== exp_level[9:0]) begin errors++; $display("FAIL glitch_level: got %0d expected %0d", duty_level, exp_level); end
    $display("glitch w=2: valid=%0d err=%0d level=%0d", obs_nvalid, obs_nerr, duty_level);
  endtask

  task automatic test_reset_mid_pulse();
    int nv, ne;
    // Reset while measuring; the pulse ends inside the reset window.
    nv = 0; ne = 0;
    @(negedge clk);
    pwm_in = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (duty_valid) nv++;
      if (pulse_err) ne++;
      if (k == 400) rst = 1'b1;
      if (k == 402) pwm_in = 1'b0;
      if (k == 405) rst = 1'b0;
    end
    exp_level = 0;
    checks++; if (nv !== 0 || ne !== 0) begin errors++; $display("FAIL rst_measure_strobes: got valid=%0d err=%0d expected 0/0", nv, ne); end
    checks++; if (duty_level !== 10'd0) begin errors++; $display("FAIL rst_measure_level: got %0d expected 0", duty_level); end
    checks++; if (signal_lost !== 1'b1) begin errors++; $display("FAIL rst_measure_lost: got %b expected 1", signal_lost); end
    $display("reset mid-measure: valid=%0d err=%0d level=%0d lost=%b", nv, ne, duty_level, signal_lost);
    // Reset while the divider is running.
    nv = 0; ne = 0;
    @(negedge clk);
    pwm_in = 1'b1;
    for (int k = 1; k <= 880; k++) begin
      @(negedge clk);
      if (duty_valid) nv++;
      if (pulse_err) ne++;
      if (k == 750) pwm_in = 1'b0;
      if (k == 770) rst = 1'b1;
      if (k == 772) rst = 1'b0;
    end
    checks++; if (nv !== 0 || ne !== 0) begin errors++; $display("FAIL rst_convert_strobes: got valid=%0d err=%0d expected 0/0", nv, ne); end
    checks++; if (duty_level !== 10'd0) begin errors++; $display("FAIL rst_convert_level: got %0d expected 0", duty_level); end
    $display("reset mid-convert: valid=%0d err=%0d level=%0d", nv, ne, duty_level);
    test_pulse(900);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_signal_lost();
    test_glitch();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
